// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch block: FSM state encoding and PC mux selects.
package instr_fetch_pkg;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 3'd0;
    localparam fetch_state_t ST_ADDR = 3'd1;
    localparam fetch_state_t ST_WAIT = 3'd2;
    localparam fetch_state_t ST_HOLD = 3'd3;
    localparam fetch_state_t ST_ERR  = 3'd4;

    localparam logic [1:0] SEL_PC_INC = 2'b00;
    localparam logic [1:0] SEL_PC_EAB = 2'b01;
    localparam logic [1:0] SEL_PC_BUS = 2'b10;

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read bus plus the instruction-register handshake toward decode.
interface instr_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;

    modport master (output mem_addr, mem_rd, ir, ir_valid,
                    input  mem_rdata, mem_ready, ir_ready);
    modport slave  (input  mem_addr, mem_rd, ir, ir_valid,
                    output mem_rdata, mem_ready, ir_ready);
endinterface

// File: rtl/bit_16_register.sv
// 16-bit load-enabled register with asynchronous clear; used for MAR and IR.
module bit_16_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues PC to memory, captures the returned word into IR,
// and hands it to decode with a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for fetch_en
//   ADDR  | latch PC into MAR, pulse ldPC to advance the PC
//   WAIT  | memory read outstanding, bounded by TIMEOUT
//   HOLD  | IR valid, waiting for decode to accept
//   ERR   | memory timed out; sticky until reset
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_en,
    input  logic             flush,
    input  logic [15:0]      PCOut,
    output logic             ldPC,
    output logic [1:0]       selPC,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count,
    instr_fetch_if.master    bus
);
    localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [WCNT_W-1:0] wait_cnt;
    logic              timeout;
    logic              ld_mar;
    logic              ld_ir;
    logic              accept;

    assign timeout = (wait_cnt == WAIT_LAST);
    assign ld_mar  = (state_q == ST_ADDR);
    assign ld_ir   = (state_q == ST_WAIT) && bus.mem_ready && !flush;
    assign accept  = (state_q == ST_HOLD) && bus.ir_ready && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_en) state_d = ST_ADDR;
            ST_ADDR: state_d = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (flush)              state_d = ST_IDLE;
                else if (bus.mem_ready) state_d = ST_HOLD;
                else if (timeout)       state_d = ST_ERR;
            end
            ST_HOLD: begin
                if (flush)             state_d = ST_IDLE;
                else if (bus.ir_ready) state_d = fetch_en ? ST_ADDR : ST_IDLE;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Counter is held at zero outside WAIT so every WAIT entry starts a fresh window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state_q != ST_WAIT)
            wait_cnt <= '0;
        else if (!timeout)
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count <= '0;
        else if (accept)
            fetch_count <= fetch_count + 1'b1;
    end

    bit_16_register u_mar (
        .clk   (clk),
        .reset (reset),
        .ld    (ld_mar),
        .d     (PCOut),
        .q     (bus.mem_addr)
    );

    bit_16_register u_ir (
        .clk   (clk),
        .reset (reset),
        .ld    (ld_ir),
        .d     (bus.mem_rdata),
        .q     (bus.ir)
    );

    assign ldPC         = (state_q == ST_ADDR);
    assign selPC        = SEL_PC_INC;
    assign bus.mem_rd   = (state_q == ST_WAIT);
    assign bus.ir_valid = (state_q == ST_HOLD);
    assign fetch_err    = (state_q == ST_ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed corner sequences and
// randomized fetch transactions checked against a transaction-level model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] PCOut = 16'h0;
    logic        ldPC;
    logic [1:0]  selPC;
    logic        fetch_err;
    logic [3:0]  fetch_count;

    instr_fetch_if bus();

    instr_fetch #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .PCOut       (PCOut),
        .ldPC        (ldPC),
        .selPC       (selPC),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_cnt = 0;
    logic [15:0] last_ir = 16'h0;

    typedef struct {
        logic        fe, fl, rdy, irr;
        logic [15:0] rdata;
        logic        e_ld, e_rd, e_v;
        logic [15:0] e_addr, e_ir;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        last_ir = 16'h0;
    endtask

    // One complete fetch: d WAIT cycles without ready, then b HOLD cycles of backpressure.
    task automatic fetch_one(input logic [15:0] pc, input logic [15:0] data, input int d, input int b);
        fetch_en = 1'b1;
        PCOut = pc;
        check("idle_no_ldPC", ldPC, 0);
        tick();
        check("addr_ldPC", ldPC, 1);
        check("addr_no_rd", bus.mem_rd, 0);
        fetch_en = 1'b0;
        tick();
        for (int i = 0; i < d; i++) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 16'($urandom);
            check("wait_rd", bus.mem_rd, 1);
            check("wait_addr", bus.mem_addr, pc);
            check("wait_no_err", fetch_err, 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = data;
        check("wait_rd_last", bus.mem_rd, 1);
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = ~data;
        for (int i = 0; i < b; i++) begin
            bus.ir_ready = 1'b0;
            check("hold_valid", bus.ir_valid, 1);
            check("hold_ir", bus.ir, data);
            check("hold_no_ldPC", ldPC, 0);
            tick();
        end
        bus.ir_ready = 1'b1;
        check("accept_valid", bus.ir_valid, 1);
        check("accept_ir", bus.ir, data);
        tick();
        bus.ir_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 16;
        last_ir = data;
        check("count", fetch_count, exp_cnt);
        check("idle_after_accept", bus.ir_valid, 0);
    endtask

    initial begin
        int pulses;
        int start;
        bus.mem_rdata = 16'h0;
        bus.mem_ready = 1'b0;
        bus.ir_ready  = 1'b0;

        //            fe    fl    rdy   irr   rdata     ld    rd    v     addr      ir        cnt
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, 4'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h1234, 4'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h1234, 4'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h1234, 4'd1};

        #1 reset = 1'b1;
        #2;
        check("rst_ldPC", ldPC, 0);
        check("rst_rd", bus.mem_rd, 0);
        check("rst_valid", bus.ir_valid, 0);
        check("rst_err", fetch_err, 0);
        check("rst_cnt", fetch_count, 0);
        check("rst_ir", bus.ir, 0);
        check("rst_addr", bus.mem_addr, 0);
        tick();
        reset = 1'b0;

        PCOut = 16'h3000;
        for (int i = 0; i < 6; i++) begin
            fetch_en      = tbl[i].fe;
            flush         = tbl[i].fl;
            bus.mem_ready = tbl[i].rdy;
            bus.ir_ready  = tbl[i].irr;
            bus.mem_rdata = tbl[i].rdata;
            check($sformatf("vec%0d_ldPC", i), ldPC, tbl[i].e_ld);
            check($sformatf("vec%0d_selPC", i), selPC, 0);
            check($sformatf("vec%0d_rd", i), bus.mem_rd, tbl[i].e_rd);
            check($sformatf("vec%0d_valid", i), bus.ir_valid, tbl[i].e_v);
            check($sformatf("vec%0d_addr", i), bus.mem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_ir", i), bus.ir, tbl[i].e_ir);
            check($sformatf("vec%0d_cnt", i), fetch_count, tbl[i].e_cnt);
            check($sformatf("vec%0d_err", i), fetch_err, 0);
            tick();
        end
        bus.mem_ready = 1'b0;
        exp_cnt = 1;
        last_ir = 16'h1234;

        fetch_one(16'h4000, 16'hA5A5, 5, 0);
        fetch_one(16'h4001, 16'h5A5A, 0, 10);

        // Flush in WAIT racing mem_ready: nothing captured.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        flush = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        flush = 1'b0;
        bus.mem_ready = 1'b0;
        check("flushw_valid", bus.ir_valid, 0);
        check("flushw_rd", bus.mem_rd, 0);
        check("flushw_ir", bus.ir, last_ir);
        check("flushw_cnt", fetch_count, exp_cnt);
        tick();
        check("flushw_idle_ldPC", ldPC, 0);
        check("flushw_idle_valid", bus.ir_valid, 0);

        // Flush in HOLD racing ir_ready: no accept counted.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h0F0F;
        tick();
        bus.mem_ready = 1'b0;
        check("flushh_valid_pre", bus.ir_valid, 1);
        bus.ir_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.ir_ready = 1'b0;
        last_ir = 16'h0F0F;
        check("flushh_valid", bus.ir_valid, 0);
        check("flushh_ir", bus.ir, last_ir);
        check("flushh_cnt", fetch_count, exp_cnt);

        // Asynchronous reset landing mid-WAIT.
        fetch_en = 1'b1;
        PCOut = 16'h7777;
        tick();
        fetch_en = 1'b0;
        tick();
        check("arst_pre_rd", bus.mem_rd, 1);
        #3 reset = 1'b1;
        #1;
        check("arst_rd", bus.mem_rd, 0);
        check("arst_ldPC", ldPC, 0);
        check("arst_valid", bus.ir_valid, 0);
        check("arst_ir", bus.ir, 0);
        check("arst_addr", bus.mem_addr, 0);
        check("arst_cnt", fetch_count, 0);
        check("arst_err", fetch_err, 0);
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        last_ir = 16'h0;

        for (int i = 0; i < 16; i++)
            fetch_one(16'($urandom), 16'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        check("wrap_16", fetch_count, 0);
        for (int i = 0; i < 8; i++)
            fetch_one(16'($urandom), 16'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        // Back-to-back streaming with zero-wait memory.
        start = exp_cnt;
        pulses = 0;
        fetch_en = 1'b1;
        bus.ir_ready = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.mem_rdata = 16'($urandom);
            if (ldPC === 1'b1) pulses++;
            tick();
        end
        check("b2b_pulses", pulses, 10);
        check("b2b_cnt", fetch_count, (start + 9) % 16);
        fetch_en = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        bus.ir_ready = 1'b0;
        exp_cnt = (start + 10) % 16;
        check("b2b_cnt_final", fetch_count, exp_cnt);
        check("b2b_idle", bus.ir_valid, 0);

        // Memory timeout and sticky error.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("to_rd", bus.mem_rd, 1);
            check("to_no_err", fetch_err, 0);
            tick();
        end
        check("to_err", fetch_err, 1);
        check("to_rd_off", bus.mem_rd, 0);
        flush = 1'b1;
        fetch_en = 1'b1;
        bus.mem_ready = 1'b1;
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_sticky", fetch_err, 1);
            check("err_rd", bus.mem_rd, 0);
            check("err_ldPC", ldPC, 0);
            check("err_valid", bus.ir_valid, 0);
        end
        flush = 1'b0;
        fetch_en = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("err_cleared", fetch_err, 0);
        tick();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum WAIT cycles allowed without mem_ready.
REQ-002 Parameter CNT_W, default 16: width of retired-fetch counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_en  input  1  fetch permission; level-sensitive.
REQ-006 flush  input  1  discard in-flight fetch (redirect).
REQ-007 PCOut  input  16  current PC from PC register.
REQ-008 ldPC  output  1  PC register load enable.
REQ-009 selPC  output  2  PC mux select; 2'b00 = increment path.
REQ-010 mem_addr  output  16  memory read address (MAR).
REQ-011 mem_rd  output  1  memory read request.
REQ-012 mem_rdata  input  16  memory read data.
REQ-013 mem_ready  input  1  read data valid this cycle.
REQ-014 ir  output  16  instruction register.
REQ-015 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-016 ir_ready  input  1  decode accepts ir.
REQ-017 fetch_err  output  1  sticky memory-timeout flag.
REQ-018 fetch_count  output  CNT_W  count of accepted instructions.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, WAIT, HOLD, ERR.
REQ-020 IDLE: fetch_en=1 -> ADDR next cycle; else stay.
REQ-021 ADDR (one cycle): MAR <= PCOut; ldPC=1; selPC=2'b00; -> WAIT.
REQ-022 ldPC SHALL be 1 only in ADDR; selPC SHALL be constant 2'b00.
REQ-023 WAIT: mem_rd=1, mem_addr=MAR; mem_ready=1 -> ir <= mem_rdata, -> HOLD.
REQ-024 WAIT cycle counter SHALL clear on entering WAIT; mem_ready absent for TIMEOUT consecutive WAIT cycles -> ERR.
REQ-025 HOLD: ir_valid=1, ir stable; ir_ready=1 -> fetch_count+1 (modulo 2^CNT_W, wraps to 0), then ADDR if fetch_en else IDLE.
REQ-026 HOLD with ir_ready=0 SHALL stay in HOLD indefinitely (no timeout).
REQ-027 ERR: fetch_err=1, mem_rd=0, ldPC=0, ir_valid=0; exit only via reset.
REQ-028 flush=1 in ADDR/WAIT/HOLD -> IDLE next cycle; overrides mem_ready, ir_ready, and timeout in the same cycle; no fetch_count increment; ir unchanged; flush ignored in IDLE and ERR.
REQ-029 Minimum latency, zero-wait memory: fetch_en sampled in IDLE at cycle 0 -> ir_valid=1 at cycle 3.
REQ-030 Back-to-back: with fetch_en=1, ir_ready=1, zero-wait memory, one instruction per 3 cycles.
REQ-031 mem_rdata SHALL be ignored outside WAIT.

Reset
REQ-032 reset=1 SHALL immediately force: state IDLE, MAR=0, ir=0, ir_valid=0, mem_rd=0, ldPC=0, fetch_err=0, fetch_count=0, WAIT counter=0.
REQ-033 Reset mid-WAIT SHALL abandon the read; mem_rd deasserted without waiting for mem_ready.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding and selPC constants (SEL_PC_INC=2'b00, SEL_PC_EAB=2'b01, SEL_PC_BUS=2'b10).
REQ-035 MAR and ir SHALL each be an instance of bit_16_register; no other sub-module.

Verification
REQ-036 Zero-wait: PCOut=16'h3000, mem_rdata=16'h1234 ready in first WAIT cycle -> ldPC pulse at cycle 1, mem_addr=16'h3000, ir=16'h1234 with ir_valid at cycle 3, fetch_count=1 after accept.
REQ-037 Wait states: mem_ready delayed 5 cycles, TIMEOUT=8 -> no error, ir captured, mem_rd held all 5 cycles.
REQ-038 Timeout: mem_ready never asserted -> ERR after 8 WAIT cycles, fetch_err=1 and sticky until reset.
REQ-039 Flush with simultaneous mem_ready in WAIT -> IDLE, ir_valid stays 0, ir unchanged, fetch_count unchanged.
REQ-040 Backpressure and wrap: ir_ready=0 for 10 cycles -> ir stable, no ldPC; CNT_W=4 after 16 accepts -> fetch_count=0.
REQ-041 Async reset mid-WAIT -> all outputs at reset values before the next clock edge.
